// File: rtl/mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mul_sequencer
// Description : Iterative shift-and-add multiplier sequencer (IDLE/RUN/DONE)
//               with decode stall, flush abort and register-file writeback.
//               Optional early termination: define MUL_EARLY_TERM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_sequencer #(
  parameter int WORD_LENGTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   flush,
  input  logic [WORD_LENGTH-1:0] operand_a,
  input  logic [WORD_LENGTH-1:0] operand_b,
  input  logic [3:0]             dest_in,
  input  logic                   s_in,
  output logic                   stall_out,
  output logic                   busy,
  output logic                   done,
  output logic [WORD_LENGTH-1:0] result,
  output logic [3:0]             dest_out,
  output logic                   wb_en_out,
  output logic                   n_flag,
  output logic                   z_flag,
  output logic                   status_write_out
);

  localparam int                 CNT_W  = $clog2(WORD_LENGTH + 1);
  localparam logic [CNT_W-1:0]   C_LAST = CNT_W'(WORD_LENGTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;

  logic [WORD_LENGTH-1:0] r_acc;
  logic [WORD_LENGTH-1:0] r_mcand;
  logic [WORD_LENGTH-1:0] r_mplier;
  logic [WORD_LENGTH-1:0] r_result;
  logic [CNT_W-1:0]       r_count;
  logic [3:0]             r_dest;
  logic                   r_s;

  logic                   w_load;
  logic                   w_in_run;
  logic                   w_in_done;
  logic                   w_last_iter;
  logic                   w_finish;
  logic                   w_done;
  logic [WORD_LENGTH-1:0] w_acc_step;
  logic [WORD_LENGTH-1:0] w_mplier_step;
  logic [CNT_W-1:0]       w_count_step;

  assign w_in_run      = (r_state == ST_RUN);
  assign w_in_done     = (r_state == ST_DONE);
  assign w_load        = (r_state == ST_IDLE) && start && !flush;
  assign w_acc_step    = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_mplier_step = r_mplier >> 1;
  assign w_count_step  = r_count + 1'b1;

`ifdef MUL_EARLY_TERM_EN
  // Once no multiplier bits remain, further iterations cannot change acc.
  assign w_last_iter = (w_count_step == C_LAST) || (w_mplier_step == '0);
`else
  assign w_last_iter = (w_count_step == C_LAST);
`endif

  // Flush beats completion: the product is never committed on an aborted op.
  assign w_finish = w_in_run && !flush && w_last_iter;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start && !flush) w_state_next = ST_RUN;
      ST_RUN: begin
        if (flush)            w_state_next = ST_IDLE;
        else if (w_last_iter) w_state_next = ST_DONE;
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_count  <= '0;
      r_result <= '0;
      r_dest   <= '0;
      r_s      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_load) begin
        r_acc    <= '0;
        r_mcand  <= operand_a;
        r_mplier <= operand_b;
        r_count  <= '0;
        r_dest   <= dest_in;
        r_s      <= s_in;
      end else if (w_in_run) begin
        r_acc    <= w_acc_step;
        r_mcand  <= r_mcand << 1;
        r_mplier <= w_mplier_step;
        r_count  <= w_count_step;
      end
      if (w_finish) r_result <= w_acc_step;
    end
  end

  // Control outputs are forced low while reset is asserted.
  assign w_done           = rst && w_in_done && !flush;
  assign stall_out        = rst && (w_load || w_in_run);
  assign busy             = rst && (w_in_run || w_in_done);
  assign done             = w_done;
  assign wb_en_out        = w_done;
  assign status_write_out = w_done && r_s;
  assign n_flag           = w_done && r_result[WORD_LENGTH-1];
  assign z_flag           = w_done && (r_result == '0);
  assign result           = r_result;
  assign dest_out         = r_dest;

endmodule
`default_nettype wire

// File: tb/tb_mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_sequencer
// Description : Directed self-checking bench for mul_sequencer with a
//               transaction-level reference model checked every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_sequencer;

  localparam int W = 32;

`ifdef MUL_EARLY_TERM_EN
  localparam int L76 = 4;
  localparam int L53 = 3;
  localparam int L50 = 2;
`else
  localparam int L76 = 33;
  localparam int L53 = 33;
  localparam int L50 = 33;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [W-1:0] operand_a = '0;
  logic [W-1:0] operand_b = '0;
  logic [3:0]   dest_in = '0;
  logic         s_in = 1'b0;
  logic         stall_out, busy, done, wb_en_out, n_flag, z_flag, status_write_out;
  logic [W-1:0] result;
  logic [3:0]   dest_out;

  mul_sequencer #(.WORD_LENGTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush),
    .operand_a(operand_a), .operand_b(operand_b), .dest_in(dest_in), .s_in(s_in),
    .stall_out(stall_out), .busy(busy), .done(done), .result(result),
    .dest_out(dest_out), .wb_en_out(wb_en_out), .n_flag(n_flag), .z_flag(z_flag),
    .status_write_out(status_write_out)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int done_cnt    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Number of RUN cycles an operation with multiplier b should take.
  function automatic int runs_for(input logic [W-1:0] b);
`ifdef MUL_EARLY_TERM_EN
    int r;
    r = 1;
    for (int i = 0; i < W; i++) if (b[i]) r = i + 1;
    return r;
`else
    return W;
`endif
  endfunction

  // Reference model: phase 0 idle, 1 computing, 2 writeback cycle.
  bit           m_valid = 1'b0;
  int           m_phase = 0;
  int           m_elapsed = 0;
  int           m_runs = 0;
  logic [W-1:0] m_prod = '0;
  logic [W-1:0] m_res = '0;
  logic [3:0]   m_dest = '0;
  logic         m_s = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      m_valid <= 1'b1;
      m_phase <= 0;
      m_res   <= '0;
      m_dest  <= '0;
      m_s     <= 1'b0;
    end else begin
      case (m_phase)
        0: if (start && !flush) begin
          m_phase   <= 1;
          m_elapsed <= 0;
          m_runs    <= runs_for(operand_b);
          m_prod    <= operand_a * operand_b;
          m_dest    <= dest_in;
          m_s       <= s_in;
        end
        1: begin
          if (flush) m_phase <= 0;
          else if (m_elapsed + 1 == m_runs) begin
            m_phase <= 2;
            m_res   <= m_prod;
          end else m_elapsed <= m_elapsed + 1;
        end
        default: m_phase <= 0;
      endcase
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        chk("stall_out", stall_out, rst && ((m_phase == 0 && start && !flush) || m_phase == 1));
        chk("busy", busy, rst && m_phase != 0);
        chk("done", done, rst && m_phase == 2 && !flush);
        chk("wb_en_out", wb_en_out, rst && m_phase == 2 && !flush);
        chk("status_write_out", status_write_out, rst && m_phase == 2 && !flush && m_s);
        chk("n_flag", n_flag, rst && m_phase == 2 && !flush && m_res[W-1]);
        chk("z_flag", z_flag, rst && m_phase == 2 && !flush && (m_res == '0));
        chk("result", result, m_res);
        chk("dest_out", dest_out, m_dest);
        if (done === 1'b1) done_cnt++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after an edge; that cycle becomes cycle 0. Returns in cycle 1.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [3:0] d, input logic s);
    operand_a = a;
    operand_b = b;
    dest_in   = d;
    s_in      = s;
    start     = 1'b1;
    @(negedge clk);
    chk("issue_stall", stall_out, 1'b1);
    step();
    start = 1'b0;
  endtask

  // Returns at the negedge of the done cycle, lat = cycle index or -1.
  task automatic wait_done(input int from, output int lat);
    lat = -1;
    for (int i = from; i <= from + 100; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = i;
        break;
      end
      step();
    end
  endtask

  initial begin
    int lat;
    int c0;
    int l;

    repeat (3) step();
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_stall", stall_out, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_z", z_flag, 1'b0);
    chk("rst_result", result, 32'h0);
    chk("rst_dest", dest_out, 4'h0);
    step();
    rst = 1'b1;
    step();

    // 7 * 6 with status update
    issue(32'd7, 32'd6, 4'd3, 1'b1);
    wait_done(1, lat);
    chk("t1_latency", lat, L76);
    chk("t1_result", result, 32'd42);
    chk("t1_dest", dest_out, 4'd3);
    chk("t1_n", n_flag, 1'b0);
    chk("t1_z", z_flag, 1'b0);
    chk("t1_sw", status_write_out, 1'b1);
    chk("t1_wb", wb_en_out, 1'b1);
    chk("t1_stall_in_done", stall_out, 1'b0);
    step();

    // zero multiplier
    issue(32'h1234, 32'd0, 4'd1, 1'b1);
    wait_done(1, lat);
    chk("t2_latency", lat, L50);
    chk("t2_result", result, 32'd0);
    chk("t2_z", z_flag, 1'b1);
    step();

    // wraparound, negative result
    issue(32'hFFFF_FFFF, 32'd2, 4'd5, 1'b0);
    wait_done(1, lat);
    chk("t3_latency", lat, runs_for(32'd2) + 1);
    chk("t3_result", result, 32'hFFFF_FFFE);
    chk("t3_n", n_flag, 1'b1);
    chk("t3_z", z_flag, 1'b0);
    chk("t3_sw", status_write_out, 1'b0);
    step();

    issue(32'd5, 32'd3, 4'd8, 1'b1);
    wait_done(1, lat);
    chk("t4_latency", lat, L53);
    chk("t4_result", result, 32'd15);
    step();

    // flush at cycle 10 of a long run
    c0 = done_cnt;
    issue(32'hDEAD, 32'hFFFF_FFFF, 4'd7, 1'b1);
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("t5_busy_c11", busy, 1'b0);
    chk("t5_result_held", result, 32'd15);
    repeat (40) step();
    chk("t5_no_done", done_cnt, c0);

    // start during RUN is ignored
    c0 = done_cnt;
    issue(32'd3, 32'h8000_0001, 4'd9, 1'b1);
    repeat (4) step();
    operand_a = 32'd9;
    operand_b = 32'd9;
    dest_in   = 4'd2;
    start     = 1'b1;
    step();
    start = 1'b0;
    wait_done(6, lat);
    chk("t6_latency", lat, 33);
    chk("t6_result", result, 32'h8000_0003);
    chk("t6_dest", dest_out, 4'd9);
    chk("t6_n", n_flag, 1'b1);
    repeat (40) step();
    chk("t6_single_done", done_cnt, c0 + 1);

    // reset at cycle 12 of a run
    c0 = done_cnt;
    issue(32'h11, 32'hFFFF_FFFF, 4'd4, 1'b1);
    repeat (11) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("t7_busy", busy, 1'b0);
    chk("t7_stall", stall_out, 1'b0);
    chk("t7_done", done, 1'b0);
    chk("t7_result", result, 32'd0);
    chk("t7_dest", dest_out, 4'd0);
    repeat (40) step();
    chk("t7_no_done", done_cnt, c0);

    // flush during the DONE cycle
    c0 = done_cnt;
    l = runs_for(32'd3) + 1;
    issue(32'd2, 32'd3, 4'd6, 1'b1);
    repeat (l - 1) step();
    flush = 1'b1;
    @(negedge clk);
    chk("t8_done", done, 1'b0);
    chk("t8_wb", wb_en_out, 1'b0);
    chk("t8_sw", status_write_out, 1'b0);
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("t8_busy_after", busy, 1'b0);
    chk("t8_result", result, 32'd6);
    step();
    chk("t8_no_done", done_cnt, c0);

    // flush coinciding with the last iteration
    c0 = done_cnt;
    l = runs_for(32'd5) + 1;
    issue(32'd4, 32'd5, 4'd2, 1'b1);
    repeat (l - 2) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("t9_busy", busy, 1'b0);
    chk("t9_done", done, 1'b0);
    chk("t9_result", result, 32'd6);
    repeat (5) step();
    chk("t9_no_done", done_cnt, c0);

    // flush and start together in IDLE
    operand_a = 32'd10;
    operand_b = 32'd10;
    start = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    chk("t10_stall", stall_out, 1'b0);
    step();
    start = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    chk("t10_busy", busy, 1'b0);
    step();

    // product overflowing to exactly zero
    issue(32'h0001_0000, 32'h0001_0000, 4'd15, 1'b1);
    wait_done(1, lat);
    chk("t11_latency", lat, runs_for(32'h0001_0000) + 1);
    chk("t11_result", result, 32'd0);
    chk("t11_z", z_flag, 1'b1);
    chk("t11_dest", dest_out, 4'd15);
    step();
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
